rete_totale_multicanale: RTL and testbench

//  Parametrised successor of the two-level "type-A lanes + type-B reducer" network.
//  - N lanes each accumulate one W-bit slice of the input word.
//  - Each lane also adds a registered feedback bit fb.
//  - A reducer XOR-folds all lane accumulators into a W-bit result, delivered on a valid/ready handshake.
//  - Unlike the combinational original, feedback is registered, blocks are LEN words long, and output supports backpressure.

---
 rtl/rete_totale_pkg.sv | 26 ++
 rtl/rete_totale_multicanale_lane.sv | 37 +++
 rtl/rete_totale_multicanale.sv | 100 ++++++++++
 tb/tb_rete_totale_multicanale.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/rete_totale_pkg.sv
// Shared types and the lane-fold reducer for rete_totale_multicanale.
package rete_totale_pkg;

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      REDUCE = 2'd1,
      EMIT   = 2'd2
   } state_t;

   localparam int MAX_W = 16;
   localparam int MAX_N = 16;
   localparam int MAX_V = MAX_N * 2 * MAX_W;

   // Each lane contributes hi^lo of its 2W-bit accumulator. All lanes are then XORed together.
   // The accumulator vector is packed lane 0 first, at a stride of 2*w bits.
   function automatic logic [MAX_W-1:0] fold(input logic [MAX_V-1:0] accv, input int w, input int n);
      logic [MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_N; i++)
         for (int j = 0; j < MAX_W; j++)
            if (i < n && j < w)
               r[j] = r[j] ^ accv[i*2*w + j] ^ accv[i*2*w + w + j];
      return r;
   endfunction

endpackage

// File: rtl/rete_totale_multicanale_lane.sv
// One lane accumulator: acc += zext(slice) + fb.
// The sum wraps by default and saturates when RETE_TOTALE_SAT_EN is defined.
module rete_lane
   import rete_totale_pkg::*;
#(
   parameter int W = 4
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           clr,
   input  logic           en,
   input  logic [W-1:0]   slice,
   input  logic           fb,
   output logic [2*W-1:0] acc
);

`ifdef RETE_TOTALE_SAT_EN
   logic [2*W:0] sum;
   assign sum = {1'b0, acc} + (2*W+1)'(slice) + (2*W+1)'(fb);
`else
   logic [2*W-1:0] sum;
   assign sum = acc + (2*W)'(slice) + (2*W)'(fb);
`endif

   always_ff @(posedge clock) begin
      if (reset || clr)
         acc <= '0;
      else if (en) begin
`ifdef RETE_TOTALE_SAT_EN
         acc <= sum[2*W] ? '1 : sum[2*W-1:0];
`else
         acc <= sum;
`endif
      end
   end

endmodule

// File: rtl/rete_totale_multicanale.sv
// N-lane block accumulator with an XOR-fold reducer, registered feedback and a backpressured result.
// Optional RETE_TOTALE_SAT_EN makes the lane adders saturate instead of wrapping.
module rete_totale_multicanale
   import rete_totale_pkg::*;
#(
   parameter int W   = 4,
   parameter int N   = 2,
   parameter int LEN = 4
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [N*W-1:0] x,
   input  logic           x_valid,
   output logic           x_ready,
   output logic [W-1:0]   z,
   output logic           z_valid,
   input  logic           z_ready
);

   localparam int CW = $clog2(LEN + 1);

   state_t             state;
   logic [CW-1:0]      cnt;
   logic               fb;
   logic               accept;
   logic               clr;
   logic [N*2*W-1:0]   acc_flat;
   logic [MAX_V-1:0]   acc_ext;
   logic [MAX_W-1:0]   f_full;
   logic [W-1:0]       f;

   // x_ready is high only in ACCUM and z_valid only in EMIT, so these gates cover the states.
   assign accept = x_valid & x_ready;
   assign clr    = z_valid & z_ready;

   for (genvar i = 0; i < N; i++) begin : g_lane
      rete_lane #(.W(W)) u_lane (
         .clock (clock),
         .reset (reset),
         .clr   (clr),
         .en    (accept),
         .slice (x[i*W +: W]),
         .fb    (fb),
         .acc   (acc_flat[i*2*W +: 2*W])
      );
   end

   assign acc_ext = MAX_V'(acc_flat);
   assign f_full  = fold(acc_ext, W, N);
   assign f       = f_full[W-1:0];

   if (W < MAX_W) begin : g_pad
      logic unused_fold_hi;
      assign unused_fold_hi = ^f_full[MAX_W-1:W];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= ACCUM;
         cnt     <= '0;
         fb      <= 1'b0;
         z       <= '0;
         z_valid <= 1'b0;
         x_ready <= 1'b1;
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  if (cnt == CW'(LEN - 1)) begin
                     cnt     <= '0;
                     state   <= REDUCE;
                     x_ready <= 1'b0;
                  end else
                     cnt <= cnt + 1'b1;
               end
            end
            REDUCE: begin
               z       <= f;
               fb      <= f[0];
               state   <= EMIT;
               z_valid <= 1'b1;
            end
            EMIT: begin
               if (z_ready) begin
                  state   <= ACCUM;
                  z_valid <= 1'b0;
                  x_ready <= 1'b1;
               end
            end
            default: begin
               state   <= ACCUM;
               cnt     <= '0;
               z_valid <= 1'b0;
               x_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rete_totale_multicanale.sv
// Directed bench: a LEN=4 instance for the main sequence and a LEN=32 instance for wrap vs saturate.
module tb_rete_totale_multicanale;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] x, x2;
   logic       x_valid, x_valid2, z_ready, z_ready2;
   logic       x_ready, x_ready2, z_valid, z_valid2;
   logic [3:0] z, z2;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   rete_totale_multicanale #(.W(4), .N(2), .LEN(4)) u_dut (
      .clock(clock), .reset(reset), .x(x), .x_valid(x_valid), .x_ready(x_ready),
      .z(z), .z_valid(z_valid), .z_ready(z_ready)
   );

   rete_totale_multicanale #(.W(4), .N(2), .LEN(32)) u_dut32 (
      .clock(clock), .reset(reset), .x(x2), .x_valid(x_valid2), .x_ready(x_ready2),
      .z(z2), .z_valid(z_valid2), .z_ready(z_ready2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered and left at a negedge; the word is taken on the first posedge that sees x_ready.
   task automatic push(input logic [7:0] d);
      int n = 0;
      x = d; x_valid = 1'b1;
      while (!x_ready && n < 50) begin @(negedge clock); n++; end
      if (n >= 50) check("push_timeout", 32'd0, 32'd1);
      @(negedge clock);
      x_valid = 1'b0;
   endtask

   task automatic push2(input logic [7:0] d);
      int n = 0;
      x2 = d; x_valid2 = 1'b1;
      while (!x_ready2 && n < 50) begin @(negedge clock); n++; end
      if (n >= 50) check("push2_timeout", 32'd0, 32'd1);
      @(negedge clock);
      x_valid2 = 1'b0;
   endtask

   task automatic block(input logic [7:0] d);
      for (int k = 0; k < 4; k++) push(d);
   endtask

   initial begin
      logic [7:0] exp_acc32;
      logic [3:0] exp_z32;
`ifdef RETE_TOTALE_SAT_EN
      exp_acc32 = 8'hFF; exp_z32 = 4'h0;
`else
      exp_acc32 = 8'hE0; exp_z32 = 4'hE;
`endif
      reset = 1'b1; x = '0; x_valid = 1'b0; z_ready = 1'b0;
      x2 = '0; x_valid2 = 1'b0; z_ready2 = 1'b1;

      // 1: reset and idle
      @(negedge clock); @(negedge clock);
      check("rst_z", z, 4'h0);
      check("rst_zv", z_valid, 1'b0);
      check("rst_xr", x_ready, 1'b1);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check("idle_xr", x_ready, 1'b1);
         check("idle_zv", z_valid, 1'b0);
         check("idle_cnt", u_dut.cnt, 0);
      end

      // 2: basic block, latency and return to ACCUM
      z_ready = 1'b1;
      block(8'h21);
      check("basic_reduce_zv", z_valid, 1'b0);
      @(negedge clock);
      check("basic_zv", z_valid, 1'b1);
      check("basic_z", z, 4'hC);
      check("basic_fb", u_dut.fb, 1'b0);
      check("basic_acc0", u_dut.g_lane[0].u_lane.acc, 8'h04);
      check("basic_acc1", u_dut.g_lane[1].u_lane.acc, 8'h08);
      @(negedge clock);
      check("basic_xr_after", x_ready, 1'b1);
      check("basic_zv_after", z_valid, 1'b0);

      // 3: feedback carried into the next block
      block(8'h05);
      @(negedge clock);
      check("fb1_z", z, 4'h5);
      check("fb1_acc0", u_dut.g_lane[0].u_lane.acc, 8'h14);
      check("fb1_fb", u_dut.fb, 1'b1);
      @(negedge clock);
      block(8'h00);
      @(negedge clock);
      check("fb2_z", z, 4'h0);
      check("fb2_acc0", u_dut.g_lane[0].u_lane.acc, 8'h04);
      check("fb2_acc1", u_dut.g_lane[1].u_lane.acc, 8'h04);
      check("fb2_fb", u_dut.fb, 1'b0);
      @(negedge clock);

      // 4: backpressure with x_valid pulses ignored
      z_ready = 1'b0;
      block(8'h21);
      @(negedge clock);
      for (int i = 0; i < 5; i++) begin
         check("bp_zv", z_valid, 1'b1);
         check("bp_z", z, 4'hC);
         check("bp_xr", x_ready, 1'b0);
         x = 8'hFF; x_valid = i[0];
         @(negedge clock);
      end
      x_valid = 1'b0;
      check("bp_cnt", u_dut.cnt, 0);
      check("bp_acc0", u_dut.g_lane[0].u_lane.acc, 8'h04);
      check("bp_acc1", u_dut.g_lane[1].u_lane.acc, 8'h08);
      z_ready = 1'b1;
      @(negedge clock);
      check("bp_rel_xr", x_ready, 1'b1);
      check("bp_rel_zv", z_valid, 1'b0);
      check("bp_rel_z", z, 4'hC);
      check("bp_rel_acc0", u_dut.g_lane[0].u_lane.acc, 8'h00);

      // 5: LEN=32, wrap or saturate
      for (int i = 0; i < 32; i++) push2(8'h0F);
      @(negedge clock);
      check("len32_zv", z_valid2, 1'b1);
      check("len32_acc0", u_dut32.g_lane[0].u_lane.acc, exp_acc32);
      check("len32_z", z2, exp_z32);
      @(negedge clock);

      // 6: reset in the middle of a block after fb was set
      block(8'h05);
      @(negedge clock);
      check("mid_pre_z", z, 4'h5);
      @(negedge clock);
      push(8'h21); push(8'h21);
      check("mid_cnt2", u_dut.cnt, 2);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("mid_cnt", u_dut.cnt, 0);
      check("mid_fb", u_dut.fb, 1'b0);
      check("mid_acc0", u_dut.g_lane[0].u_lane.acc, 8'h00);
      check("mid_acc1", u_dut.g_lane[1].u_lane.acc, 8'h00);
      check("mid_z", z, 4'h0);
      check("mid_xr", x_ready, 1'b1);
      block(8'h21);
      @(negedge clock);
      check("mid_post_zv", z_valid, 1'b1);
      check("mid_post_z", z, 4'hC);
      @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
